// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter for the single FIFO write port, shared by NUM_REQ producers.
// The grant is held for a burst of up to MAX_BURST words and stalls while Fifo_full is set.
`default_nettype none

module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int Width     = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BCW      = $clog2(MAX_BURST) + 1
) (
  input  logic                     Wr_clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ*Width-1:0] Req_data,
  input  logic [NUM_REQ-1:0]       Req_last,
  input  logic                     Fifo_full,
  output logic [NUM_REQ-1:0]       Gnt,
  output logic                     Fifo_wr_en,
  output logic [Width-1:0]         Fifo_wr_data,
  output logic                     Busy,
  output logic [IDW-1:0]           Owner_id,
  output logic [CNT_W-1:0]         Wr_count
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   owner_q;
  logic [IDW-1:0]   last_served_q;
  logic [BCW-1:0]   beat_cnt_q;
  logic [CNT_W-1:0] wr_count_q;

  logic [IDW-1:0]   pick_d;
  logic             owner_req;
  logic             owner_last;
  logic             accept;
  logic             burst_limit;

  logic [Width-1:0] req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = Req_data[gi*Width +: Width];
  end

  // Rotating priority: scan downwards so the lowest offset from last_served+1 wins.
  always_comb begin
    logic [IDW-1:0] idx;
    pick_d = last_served_q;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(last_served_q) + 1 + k) % NUM_REQ);
      if (Req[idx]) pick_d = idx;
    end
  end

  assign owner_req   = Req[owner_q];
  assign owner_last  = Req_last[owner_q];
  assign accept      = (state_q == S_BURST) && owner_req && !Fifo_full;
  assign burst_limit = (beat_cnt_q == BCW'(MAX_BURST - 1));

  assign Gnt          = accept ? (NUM_REQ'(1) << owner_q) : '0;
  assign Fifo_wr_en   = accept;
  assign Fifo_wr_data = accept ? req_word[owner_q] : '0;
  assign Busy         = (state_q == S_BURST);
  assign Owner_id     = owner_q;
  assign Wr_count     = wr_count_q;

  always_ff @(posedge Wr_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      last_served_q <= IDW'(NUM_REQ - 1);
      beat_cnt_q    <= '0;
      wr_count_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|Req) begin
            owner_q    <= pick_d;
            beat_cnt_q <= '0;
            state_q    <= S_BURST;
          end
        end
        S_BURST: begin
          if (!owner_req) begin
            state_q       <= S_IDLE;
            last_served_q <= owner_q;
          end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            wr_count_q <= wr_count_q + 1'b1;
            if (owner_last || burst_limit) begin
              state_q       <= S_IDLE;
              last_served_q <= owner_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: table vectors, hand-written corner sequences and a randomized run
// compared against a behavioural model of the round-robin burst arbiter.
`default_nettype none

module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int W  = 4;
  localparam int MB = 4;
  localparam int CW = 16;

  logic          Wr_clk = 1'b0;
  logic          reset;
  logic [NR-1:0] Req;
  logic [NR*W-1:0] Req_data;
  logic [NR-1:0] Req_last;
  logic          Fifo_full;
  logic [NR-1:0] Gnt;
  logic          Fifo_wr_en;
  logic [W-1:0]  Fifo_wr_data;
  logic          Busy;
  logic [1:0]    Owner_id;
  logic [CW-1:0] Wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Wr_clk = ~Wr_clk;

  fifo_write_arbiter #(
    .NUM_REQ(NR), .Width(W), .MAX_BURST(MB), .CNT_W(CW)
  ) dut (
    .Wr_clk(Wr_clk), .reset(reset), .Req(Req), .Req_data(Req_data),
    .Req_last(Req_last), .Fifo_full(Fifo_full), .Gnt(Gnt),
    .Fifo_wr_en(Fifo_wr_en), .Fifo_wr_data(Fifo_wr_data), .Busy(Busy),
    .Owner_id(Owner_id), .Wr_count(Wr_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, how many words it has written, who was served last.
  bit model_busy;
  int model_owner, model_beats, model_last_served, model_count;

  task automatic model_reset();
    model_busy = 0; model_owner = 0; model_beats = 0;
    model_last_served = NR - 1; model_count = 0;
  endtask

  task automatic model_check(input string tag);
    bit acc;
    logic [NR-1:0] eg;
    logic [W-1:0]  ed;
    acc = model_busy && Req[model_owner] && !Fifo_full;
    eg  = acc ? NR'(1 << model_owner) : '0;
    ed  = acc ? Req_data[model_owner*W +: W] : '0;
    chk({tag, ".gnt"},   32'(Gnt), 32'(eg));
    chk({tag, ".wen"},   32'(Fifo_wr_en), 32'(acc));
    chk({tag, ".data"},  32'(Fifo_wr_data), 32'(ed));
    chk({tag, ".busy"},  32'(Busy), 32'(model_busy));
    chk({tag, ".owner"}, 32'(Owner_id), 32'(model_owner));
    chk({tag, ".count"}, 32'(Wr_count), 32'(model_count));
  endtask

  task automatic model_step();
    bit found;
    if (!model_busy) begin
      if (Req != '0) begin
        found = 0;
        for (int k = 1; k <= NR; k++) begin
          if (!found && Req[(model_last_served + k) % NR]) begin
            model_owner = (model_last_served + k) % NR;
            found = 1;
          end
        end
        model_busy  = 1;
        model_beats = 0;
      end
    end else if (!Req[model_owner]) begin
      model_busy = 0;
      model_last_served = model_owner;
    end else if (!Fifo_full) begin
      model_beats++;
      model_count = (model_count + 1) % (1 << CW);
      if (Req_last[model_owner] || model_beats == MB) begin
        model_busy = 0;
        model_last_served = model_owner;
      end
    end
  endtask

  // Inputs are applied just after a negedge; outputs are sampled 2ns later, clear of the posedge.
  task automatic next_cycle();
    @(posedge Wr_clk);
    model_step();
    @(negedge Wr_clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    Req = 4'($urandom); Req_last = 4'($urandom);
    Req_data = 16'($urandom); Fifo_full = 1'($urandom);
    @(negedge Wr_clk);
    @(negedge Wr_clk);
    #2;
    chk("rst.gnt",   32'(Gnt), 0);
    chk("rst.wen",   32'(Fifo_wr_en), 0);
    chk("rst.data",  32'(Fifo_wr_data), 0);
    chk("rst.busy",  32'(Busy), 0);
    chk("rst.owner", 32'(Owner_id), 0);
    chk("rst.count", 32'(Wr_count), 0);
    @(negedge Wr_clk);
    reset = 1'b1;
    Req = '0; Req_last = '0; Fifo_full = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  gnt;
    logic        wen;
    logic [3:0]  data;
    logic        busy;
    logic [1:0]  owner;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [14];

  initial begin
    reset = 1'b0; Req = '0; Req_last = '0; Req_data = '0; Fifo_full = 1'b0;
    model_reset();

    // Single requester, rotation after a completed burst, stall then withdraw.
    vecs[0]  = '{4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0, 16'd0};
    vecs[1]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 4'h5, 1'b1, 2'd2, 16'd0};
    vecs[2]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 4'h5, 1'b1, 2'd2, 16'd1};
    vecs[3]  = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'h5, 1'b1, 2'd2, 16'd2};
    vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd2, 16'd3};
    vecs[5]  = '{4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd2, 16'd3};
    vecs[6]  = '{4'b1001, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'hA, 1'b1, 2'd3, 16'd3};
    vecs[7]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd3, 16'd4};
    vecs[8]  = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b1, 2'd0, 16'd4};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 2'd0, 16'd4};
    vecs[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0, 16'd4};
    vecs[11] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0, 16'd4};
    vecs[12] = '{4'b1111, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'hC, 1'b1, 2'd1, 16'd4};
    vecs[13] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd1, 16'd5};

    @(negedge Wr_clk);
    do_reset();

    Req_data = 16'hA5C3;
    for (int i = 0; i < 14; i++) begin
      Req = vecs[i].req; Req_last = vecs[i].last; Fifo_full = vecs[i].full;
      #2;
      chk($sformatf("vec%0d.gnt", i),   32'(Gnt), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d.wen", i),   32'(Fifo_wr_en), 32'(vecs[i].wen));
      chk($sformatf("vec%0d.data", i),  32'(Fifo_wr_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d.busy", i),  32'(Busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d.owner", i), 32'(Owner_id), 32'(vecs[i].owner));
      chk($sformatf("vec%0d.count", i), 32'(Wr_count), 32'(vecs[i].cnt));
      next_cycle();
    end

    // Round robin with all requesters held: arbitration cycle then MAX_BURST words per owner.
    do_reset();
    Req = 4'b1111; Req_last = '0; Req_data = 16'h4321;
    for (int c = 0; c < 26; c++) begin
      #2;
      chk($sformatf("rr%0d.gnt", c), 32'(Gnt),
          (c % 5 == 0) ? 32'd0 : 32'(1 << ((c / 5) % 4)));
      next_cycle();
    end
    #2;
    chk("rr.count", 32'(Wr_count), 32'd20);
    @(negedge Wr_clk);

    // Full stall after two words: the beat count must survive the stall.
    do_reset();
    Req = 4'b0001; Req_data = 16'h0009;
    for (int c = 0; c < 11; c++) begin
      Fifo_full = (c >= 3 && c <= 7);
      #2;
      chk($sformatf("stall%0d.wen", c), 32'(Fifo_wr_en),
          (c == 1 || c == 2 || c == 8 || c == 9) ? 32'd1 : 32'd0);
      chk($sformatf("stall%0d.busy", c), 32'(Busy),
          (c >= 1 && c <= 9) ? 32'd1 : 32'd0);
      next_cycle();
    end
    #2;
    chk("stall.count", 32'(Wr_count), 32'd4);
    @(negedge Wr_clk);

    // Asynchronous reset while the second word is being presented.
    do_reset();
    Req = 4'b0010; Req_data = 16'h00F0;
    next_cycle();
    next_cycle();
    #2;
    chk("arst.pre_wen", 32'(Fifo_wr_en), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst.gnt",   32'(Gnt), 0);
    chk("arst.wen",   32'(Fifo_wr_en), 0);
    chk("arst.data",  32'(Fifo_wr_data), 0);
    chk("arst.busy",  32'(Busy), 0);
    chk("arst.owner", 32'(Owner_id), 0);
    chk("arst.count", 32'(Wr_count), 0);
    @(negedge Wr_clk);
    reset = 1'b1; Req = 4'b1111; Req_last = '0;
    next_cycle();
    #2;
    chk("arst.regnt",  32'(Gnt), 32'b0001);
    chk("arst.reown",  32'(Owner_id), 0);
    chk("arst.recnt0", 32'(Wr_count), 0);
    next_cycle();
    #2;
    chk("arst.recnt1", 32'(Wr_count), 1);
    @(negedge Wr_clk);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      Req       = 4'($urandom) | 4'($urandom);
      Req_last  = 4'($urandom) & 4'($urandom);
      Req_data  = 16'($urandom);
      Fifo_full = ($urandom_range(0, 4) == 0);
      #2;
      model_check($sformatf("rnd%0d", c));
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
